// File: rtl/uart_vip_pkg.sv
// Shared types and constants for the UART transmitter slice: FSM state
// encoding, data width and frame length helper.
package uart_vip_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } tx_state_e;

    localparam int unsigned DATA_BITS = 8;

    // Bits on the wire per frame: start + data + optional parity + stop.
    function automatic int unsigned frame_bits(input bit parity_en);
        return 1 + DATA_BITS + (parity_en ? 1 : 0) + 1;
    endfunction

endpackage

// File: rtl/uart_vip_tx_if.sv
// Byte-stream valid/ready handshake feeding the transmitter FIFO.
interface uart_vip_tx_if;
    logic [7:0] data_i;
    logic       valid_i;
    logic       ready_o;

    modport master (output data_i, output valid_i, input ready_o);
    modport slave  (input data_i, input valid_i, output ready_o);
endinterface

// File: rtl/uart_vip_fifo.sv
// Synchronous first-word-fall-through FIFO; DEPTH must be a power of two so
// the pointers wrap naturally, and the count carries one extra bit.
module uart_vip_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] din_i,
    output logic [WIDTH-1:0] dout_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int unsigned AW    = $clog2(DEPTH);
    localparam int unsigned CNT_W = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign dout_o  = mem_q[rd_ptr_q];
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        unique case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // NOTE: state flops use non-blocking assignments so all of them update together at the edge.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage is not reset; empty/full come from the count, so stale words are never visible.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= din_i;
    end

endmodule

// File: rtl/uart_vip_tx.sv
// Buffered UART transmitter: bytes enter a FIFO through a valid/ready
// interface and leave as start/data/[parity]/stop frames on tx_o.
module uart_vip_tx
    import uart_vip_pkg::*;
#(
    parameter bit          PARITY_EN  = 1'b0,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         en_i,
    input  logic [15:0]  cfg_div_i,
    uart_vip_tx_if.slave in_if,
    output logic         tx_o,
    output logic         busy_o,
    output logic         tx_done_o
);
    localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

    tx_state_e            state_q, state_d;
    logic [15:0]          div_q, div_d;
    logic [15:0]          cnt_q, cnt_d;
    logic [2:0]           bit_idx_q, bit_idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 parity_q, parity_d;
    logic                 tx_q, tx_d;
    logic                 done_q, done_d;

    logic                 fifo_pop, fifo_full, fifo_empty;
    logic [DATA_BITS-1:0] fifo_dout;
    logic                 bit_end, start_ok, load_frame;

    uart_vip_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(DATA_BITS)) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (in_if.valid_i),
        .pop_i   (fifo_pop),
        .din_i   (in_if.data_i),
        .dout_o  (fifo_dout),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign in_if.ready_o = ~fifo_full;
    assign tx_o          = tx_q;
    assign tx_done_o     = done_q;
    assign busy_o        = (state_q != ST_IDLE) | ~fifo_empty;

    assign bit_end  = (cnt_q == '0);
    assign start_ok = ~fifo_empty & en_i;

    always_comb begin
        state_d    = state_q;
        div_d      = div_q;
        cnt_d      = bit_end ? div_q : cnt_q - 16'd1;
        bit_idx_d  = bit_idx_q;
        shift_d    = shift_q;
        parity_d   = parity_q;
        tx_d       = tx_q;
        done_d     = 1'b0;
        fifo_pop   = 1'b0;
        load_frame = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                cnt_d      = '0;
                load_frame = start_ok;
            end
            ST_START: if (bit_end) begin
                state_d   = ST_DATA;
                bit_idx_d = '0;
                tx_d      = shift_q[0];
            end
            ST_DATA: if (bit_end) begin
                if (bit_idx_q == LAST_BIT) begin
                    state_d = PARITY_EN ? ST_PARITY : ST_STOP;
                    tx_d    = PARITY_EN ? parity_q : 1'b1;
                end else begin
                    bit_idx_d = bit_idx_q + 3'd1;
                    shift_d   = shift_q >> 1;
                    tx_d      = shift_q[1];
                end
            end
            ST_PARITY: if (bit_end) begin
                state_d = ST_STOP;
                tx_d    = 1'b1;
            end
            ST_STOP: if (bit_end) begin
                done_d     = 1'b1;
                load_frame = start_ok;
                if (!start_ok) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // Pop, shifter load and divisor capture share the edge that enters START.
        if (load_frame) begin
            fifo_pop  = 1'b1;
            state_d   = ST_START;
            shift_d   = fifo_dout;
            parity_d  = ^fifo_dout;
            div_d     = cfg_div_i;
            cnt_d     = cfg_div_i;
            bit_idx_d = '0;
            tx_d      = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= ST_IDLE;
            div_q     <= '0;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            parity_q  <= 1'b0;
            tx_q      <= 1'b1;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            div_q     <= div_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            parity_q  <= parity_d;
            tx_q      <= tx_d;
            done_q    <= done_d;
        end
    end

endmodule
